// File: rtl/arb_pkg.sv
// Shared types and constants for the IF/MEM SRAM arbiter.
// Holds the FSM state and grant encodings plus the access-counter width.
package arb_pkg;

  localparam int unsigned WAIT_MAX = 15;
  localparam int unsigned CNT_W    = $clog2(WAIT_MAX + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACC_IF = 2'd1,
    ACC_DM = 2'd2,
    DONE   = 2'd3
  } state_t;

  typedef enum logic {
    GNT_IF = 1'b0,
    GNT_DM = 1'b1
  } grant_t;

endpackage

// File: rtl/wait_counter.sv
// Down-counter that times the SRAM access cycles of one transaction.
// Loaded on grant, decremented once per access cycle, flags zero on the last cycle.
module wait_counter
  import arb_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_value,
  input  logic             dec,
  output logic             zero
);

  logic [CNT_W-1:0] count_r;

  // Counter register: load has priority, decrement saturates at zero.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count_r <= {CNT_W{1'b0}};
    end else if (load) begin
      count_r <= load_value;
    end else if (dec && (count_r != {CNT_W{1'b0}})) begin
      count_r <= count_r - {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      count_r <= count_r;
    end
  end

  assign zero = (count_r == {CNT_W{1'b0}});

endmodule

// File: rtl/fetch_mem_arbiter.sv
// Arbitrates one single-ported SRAM between instruction fetch and the data stage.
// Each grant runs a fixed WAIT_CYCLES access, then pulses the winner's ready for one cycle.
module fetch_mem_arbiter
  import arb_pkg::*;
#(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned WAIT_CYCLES = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ready,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_ready,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              sram_en,
  output logic              sram_we,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata,
  output logic              busy
);

  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(WAIT_CYCLES - 1);

  state_t            state_r, state_s;
  grant_t            last_grant_r, grant_s;
  logic              squash_r;
  logic              latch_s, cnt_load_s, cnt_dec_s, cnt_zero_s;
  logic [ADDR_W-1:0] addr_r;
  logic              we_r;
  logic [DATA_W-1:0] wdata_r;

  wait_counter u_wait_counter (
    .clock      (clock),
    .reset      (reset),
    .load       (cnt_load_s),
    .load_value (LOAD_VAL),
    .dec        (cnt_dec_s),
    .zero       (cnt_zero_s)
  );

  // Next-state and grant decision; fetch only wins a tie right after a data grant.
  always_comb begin
    state_s    = state_r;
    grant_s    = last_grant_r;
    latch_s    = 1'b0;
    cnt_load_s = 1'b0;
    cnt_dec_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (dm_req && !(if_req && (last_grant_r == GNT_DM))) begin
          state_s    = ACC_DM;
          grant_s    = GNT_DM;
          latch_s    = 1'b1;
          cnt_load_s = 1'b1;
        end else if (if_req) begin
          state_s    = ACC_IF;
          grant_s    = GNT_IF;
          latch_s    = 1'b1;
          cnt_load_s = 1'b1;
        end else begin
          state_s = IDLE;
        end
      end
      ACC_IF, ACC_DM: begin
        if (cnt_zero_s) begin
          state_s = DONE;
        end else begin
          cnt_dec_s = 1'b1;
        end
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // State, grant history and the request snapshot taken at grant time.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r      <= IDLE;
      last_grant_r <= GNT_IF;
      addr_r       <= {ADDR_W{1'b0}};
      we_r         <= 1'b0;
      wdata_r      <= {DATA_W{1'b0}};
    end else begin
      state_r      <= state_s;
      last_grant_r <= grant_s;
      if (latch_s) begin
        addr_r  <= (grant_s == GNT_DM) ? dm_addr : if_addr;
        we_r    <= (grant_s == GNT_DM) && dm_we;
        wdata_r <= (grant_s == GNT_DM) ? dm_wdata : {DATA_W{1'b0}};
      end else begin
        addr_r  <= addr_r;
        we_r    <= we_r;
        wdata_r <= wdata_r;
      end
    end
  end

  // A fetch abandoned by the pipeline (branch flush) still finishes on the SRAM but is not delivered.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      squash_r <= 1'b0;
    end else if (state_r == DONE) begin
      squash_r <= 1'b0;
    end else if ((state_r == ACC_IF) && !if_req) begin
      squash_r <= 1'b1;
    end else begin
      squash_r <= squash_r;
    end
  end

  // Read-data capture on the final access cycle; stores leave dm_rdata alone.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      if_rdata <= {DATA_W{1'b0}};
      dm_rdata <= {DATA_W{1'b0}};
    end else begin
      if ((state_r == ACC_IF) && cnt_zero_s && !squash_r && if_req) begin
        if_rdata <= sram_rdata;
      end else begin
        if_rdata <= if_rdata;
      end
      if ((state_r == ACC_DM) && cnt_zero_s && !we_r) begin
        dm_rdata <= sram_rdata;
      end else begin
        dm_rdata <= dm_rdata;
      end
    end
  end

  assign sram_en    = (state_r == ACC_IF) || (state_r == ACC_DM);
  assign sram_we    = (state_r == ACC_DM) && we_r;
  assign sram_addr  = sram_en ? addr_r : {ADDR_W{1'b0}};
  assign sram_wdata = sram_en ? wdata_r : {DATA_W{1'b0}};
  assign if_ready   = (state_r == DONE) && (last_grant_r == GNT_IF) && !squash_r;
  assign dm_ready   = (state_r == DONE) && (last_grant_r == GNT_DM);
  assign busy       = (state_r != IDLE);

endmodule

// File: tb/tb_fetch_mem_arbiter.sv
// Randomized scoreboard bench for fetch_mem_arbiter with a word-level memory model
// and a transaction-level arbitration model; a negedge monitor does all output checking.
module tb_fetch_mem_arbiter;

  localparam int WAIT = 4;

  logic        clock, reset;
  logic        if_req, if_ready, dm_req, dm_we, dm_ready;
  logic [31:0] if_addr, if_rdata, dm_addr, dm_wdata, dm_rdata;
  logic        sram_en, sram_we, busy;
  logic [31:0] sram_addr, sram_wdata, sram_rdata;

  fetch_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT_CYCLES(WAIT)) dut (
    .clock(clock), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_ready(dm_ready), .dm_rdata(dm_rdata),
    .sram_en(sram_en), .sram_we(sram_we), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .sram_rdata(sram_rdata), .busy(busy)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Fetch space is words 0..63 (addr < 0x100), data space is words 64..255.
  function automatic logic [31:0] init_word(input int i);
    if (i == 4) return 32'hDEAD_BEEF;
    return 32'(i) * 32'h9E37_79B1 + 32'h1357_9BDF;
  endfunction

  // SRAM environment: data is only valid in the last access cycle.
  logic [31:0] sram_mem [0:255];
  logic [3:0]  en_cnt;
  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      en_cnt <= 4'd0;
      for (int i = 0; i < 256; i++) sram_mem[i] <= init_word(i);
    end else begin
      if (sram_en && sram_we) sram_mem[sram_addr[9:2]] <= sram_wdata;
      en_cnt <= sram_en ? en_cnt + 4'd1 : 4'd0;
    end
  end
  assign sram_rdata = (sram_en && (en_cnt == 4'(WAIT - 1))) ? sram_mem[sram_addr[9:2]]
                                                            : (32'hBAD0_0000 | {28'h0, en_cnt});

  // Reference model state
  logic [31:0] ref_mem [0:255];
  logic [31:0] if_q[$];
  bit          dm_st_q[$];
  logic [31:0] dm_dat_q[$];
  bit          grant_log[$];

  task automatic init_ref();
    for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
  endtask

  // Monitor: arbitration model, access shape, ready timing and data scoreboard.
  bit          model_last_dm, prev_en, prev_if_req, prev_dm_req, prev_dm_we, exp_dm, obs_dm;
  logic [31:0] prev_if_addr, prev_dm_addr, prev_dm_wdata, acc_addr, exp_if_last, exp_dm_last;
  bit          acc_we, st;
  int          run;
  always @(negedge clock) begin
    if (!reset) begin
      model_last_dm = 1'b0; prev_en = 1'b0; run = 0;
      exp_if_last = 32'h0; exp_dm_last = 32'h0;
      prev_if_req = 1'b0; prev_dm_req = 1'b0;
    end else begin
      if (if_ready && dm_ready) chk("both_ready", 32'd1, 32'd0);
      if (if_ready || dm_ready) chk("ready_after_access", {31'd0, prev_en && !sram_en}, 32'd1);
      if (sram_we) chk("we_outside_access", {31'd0, sram_en}, 32'd1);
      if (sram_en && !prev_en) begin
        obs_dm = (sram_addr >= 32'h100);
        if (prev_dm_req && prev_if_req) exp_dm = !model_last_dm;
        else if (prev_dm_req)           exp_dm = 1'b1;
        else if (prev_if_req)           exp_dm = 1'b0;
        else begin
          exp_dm = obs_dm;
          chk("spurious_access", 32'd1, 32'd0);
        end
        chk("arb_winner", {31'd0, obs_dm}, {31'd0, exp_dm});
        chk("grant_addr", sram_addr, exp_dm ? prev_dm_addr : prev_if_addr);
        chk("grant_we", {31'd0, sram_we}, {31'd0, exp_dm && prev_dm_we});
        if (exp_dm && prev_dm_we) chk("grant_wdata", sram_wdata, prev_dm_wdata);
        model_last_dm = exp_dm;
        grant_log.push_back(obs_dm);
        acc_addr = sram_addr; acc_we = sram_we; run = 1;
      end else if (sram_en) begin
        chk("acc_stable", {sram_addr[30:0], sram_we}, {acc_addr[30:0], acc_we});
        run++;
      end
      if (!sram_en && prev_en) chk("acc_len", 32'(run), 32'(WAIT));
      if (if_ready) begin
        if (if_q.size() == 0) chk("if_unexpected", 32'd1, 32'd0);
        else begin
          exp_if_last = if_q.pop_front();
          chk("if_rdata", if_rdata, exp_if_last);
        end
      end
      if (dm_ready) begin
        if (dm_st_q.size() == 0) chk("dm_unexpected", 32'd1, 32'd0);
        else begin
          st = dm_st_q.pop_front();
          if (st) begin
            void'(dm_dat_q.pop_front());
            chk("dm_store_rdata_hold", dm_rdata, exp_dm_last);
          end else begin
            exp_dm_last = dm_dat_q.pop_front();
            chk("dm_load_rdata", dm_rdata, exp_dm_last);
          end
        end
      end
      prev_en = sram_en; prev_if_req = if_req; prev_if_addr = if_addr;
      prev_dm_req = dm_req; prev_dm_we = dm_we; prev_dm_addr = dm_addr; prev_dm_wdata = dm_wdata;
    end
  end

  task automatic do_fetch(input logic [31:0] a, output int lat, output int busy_cnt);
    bit got = 1'b0;
    if_q.push_back(ref_mem[a[9:2]]);
    lat = 0; busy_cnt = 0;
    @(posedge clock); #1;
    if_req = 1'b1; if_addr = a;
    for (int n = 1; n <= 200; n++) begin
      @(posedge clock); #1;
      if (busy) busy_cnt++;
      if (if_ready) begin lat = n; got = 1'b1; break; end
    end
    if (!got) chk("if_timeout", 32'd0, 32'd1);
    if_req = 1'b0;
  endtask

  task automatic do_dm(input bit we, input logic [31:0] a, input logic [31:0] d, output int lat);
    bit got = 1'b0;
    if (we) begin
      ref_mem[a[9:2]] = d;
      dm_st_q.push_back(1'b1); dm_dat_q.push_back(32'h0);
    end else begin
      dm_st_q.push_back(1'b0); dm_dat_q.push_back(ref_mem[a[9:2]]);
    end
    lat = 0;
    @(posedge clock); #1;
    dm_req = 1'b1; dm_we = we; dm_addr = a; dm_wdata = d;
    for (int n = 1; n <= 200; n++) begin
      @(posedge clock); #1;
      if (dm_ready) begin lat = n; got = 1'b1; break; end
    end
    if (!got) chk("dm_timeout", 32'd0, 32'd1);
    dm_req = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  int          if_lat, dm_lat, bcnt, dummy;
  bit          saw;
  logic [4:0]  seq;
  logic [31:0] held_if;

  initial begin
    reset = 1'b0; if_req = 1'b0; if_addr = 32'h0; dm_req = 1'b0; dm_we = 1'b0;
    dm_addr = 32'h0; dm_wdata = 32'h0;
    init_ref();
    repeat (3) @(posedge clock);
    #1;
    chk("rst_sram_en", {31'd0, sram_en}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_ready", {30'd0, if_ready, dm_ready}, 32'd0);
    chk("rst_if_rdata", if_rdata, 32'd0);
    chk("rst_dm_rdata", dm_rdata, 32'd0);
    chk("rst_sram_bus", sram_addr | sram_wdata | {31'd0, sram_we}, 32'd0);
    reset = 1'b1;

    // Lone fetch
    do_fetch(32'h10, if_lat, bcnt);
    chk("lone_latency", 32'(if_lat), 32'd5);
    chk("lone_busy_cycles", 32'(bcnt), 32'd5);
    chk("lone_if_rdata", if_rdata, 32'hDEAD_BEEF);

    // Simultaneous: last grant is IF, so DM goes first
    grant_log.delete();
    fork
      do_fetch(32'h4, if_lat, dummy);
      do_dm(1'b0, 32'h100, 32'h0, dm_lat);
    join
    chk("sim_dm_latency", 32'(dm_lat), 32'd5);
    chk("sim_if_latency", 32'(if_lat), 32'd11);
    chk("sim_order_len", 32'(grant_log.size()), 32'd2);
    if (grant_log.size() == 2) chk("sim_order", {30'd0, grant_log[0], grant_log[1]}, 32'b10);

    // Starvation guard: stores back-to-back while fetch is held
    grant_log.delete();
    fork
      repeat (2) do_fetch(32'(4 * $urandom_range(0, 63)), if_lat, dummy);
      for (int k = 0; k < 3; k++) do_dm(1'b1, 32'h100 + 32'(4 * $urandom_range(0, 191)), $urandom, dm_lat);
    join
    chk("starve_len", 32'(grant_log.size()), 32'd5);
    if (grant_log.size() == 5) begin
      seq = 5'd0;
      for (int i = 0; i < 5; i++) seq = {seq[3:0], grant_log[i]};
      chk("starve_order", {27'd0, seq}, 32'b10101);
    end

    // Squash: drop fetch in the second access cycle and scramble the live address
    held_if = exp_if_last;
    @(posedge clock); #1;
    if_req = 1'b1; if_addr = 32'h20;
    @(posedge clock);
    @(posedge clock); #1;
    if_req = 1'b0; if_addr = 32'h3C;
    saw = 1'b0;
    repeat (8) begin
      @(posedge clock); #1;
      if (if_ready) saw = 1'b1;
    end
    chk("squash_no_ready", {31'd0, saw}, 32'd0);
    chk("squash_rdata_hold", if_rdata, held_if);
    do_fetch(32'h40, if_lat, dummy);
    chk("refetch_latency", 32'(if_lat), 32'd5);

    // Random traffic on both ports
    fork
      for (int k = 0; k < 20; k++) begin
        repeat ($urandom_range(0, 3)) @(posedge clock);
        do_fetch(32'(4 * $urandom_range(0, 63)), if_lat, dummy);
      end
      for (int k = 0; k < 20; k++) begin
        repeat ($urandom_range(0, 3)) @(posedge clock);
        do_dm(1'($urandom_range(0, 1)), 32'h100 + 32'(4 * $urandom_range(0, 191)), $urandom, dm_lat);
      end
    join
    do_dm(1'b0, 32'h100, 32'h0, dm_lat);

    // Reset during the third data access cycle
    @(posedge clock); #1;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h104;
    repeat (3) @(posedge clock);
    #1;
    chk("midrst_pre_en", {31'd0, sram_en}, 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("midrst_sram_en", {31'd0, sram_en}, 32'd0);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_rdata", if_rdata | dm_rdata, 32'd0);
    chk("midrst_ready", {30'd0, if_ready, dm_ready}, 32'd0);
    dm_req = 1'b0;
    init_ref();
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
    do_fetch(32'h10, if_lat, dummy);
    chk("post_rst_latency", 32'(if_lat), 32'd5);

    repeat (3) @(posedge clock);
    #1;
    chk("if_q_drained", 32'(if_q.size()), 32'd0);
    chk("dm_q_drained", 32'(dm_st_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
